// File: rtl/dsram_resp_pkg.sv
// dsram_resp_pkg: shared widths and FSM state encodings for the data-memory responder
package dsram_resp_pkg;
  localparam int DSRAM_DATA_WD = 64;
  localparam int DSRAM_WE_WD = 8;
  typedef enum logic {DSRAM_IDLE = 1'b0, DSRAM_BUSY = 1'b1} dsram_state_t;
endpackage

// File: rtl/dsram_array.sv
// dsram_array: DEPTH x 64 byte-writable array with one access port and registered read data
// Ports: clk, rst_n (sync, active-low, clears rdata only); acc performs the access at idx;
// we selects byte lanes (all-zero = read); fault suppresses the write and loads rdata with 0.
module dsram_array
  import dsram_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     acc,
  input  logic                     fault,
  input  logic [DSRAM_WE_WD-1:0]   we,
  input  logic [AW-1:0]            idx,
  input  logic [DSRAM_DATA_WD-1:0] wdata,
  output logic [DSRAM_DATA_WD-1:0] rdata
);
  logic [DSRAM_DATA_WD-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int k = 0; k < DSRAM_WE_WD; k++)
      if (acc && !fault && we[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
  // rdata changes only on a completed read or a faulting access; writes leave it alone
  always_ff @(posedge clk)
    if (!rst_n) rdata <= '0;
    else if (acc && (fault || we == '0)) rdata <= fault ? '0 : mem[idx];
endmodule

// File: rtl/dsram_resp.sv
// dsram_resp: data-SRAM responder with LATENCY-cycle access delay and stall request
// Ports: clk, rst_n (sync, active-low); data_sram_en/we/addr/wdata request from execute;
// data_sram_rdata registered read data; stall_req combinational hold; data_sram_err fault pulse.
// Optional macro DSRAM_ERR_EN: range-check the address and pulse data_sram_err on a miss;
// without it the word index wraps modulo DEPTH and data_sram_err is tied 0.
module dsram_resp
  import dsram_resp_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_sram_en,
  input  logic [DSRAM_WE_WD-1:0]   data_sram_we,
  input  logic [63:0]              data_sram_addr,
  input  logic [DSRAM_DATA_WD-1:0] data_sram_wdata,
  output logic [DSRAM_DATA_WD-1:0] data_sram_rdata,
  output logic                     stall_req,
  output logic                     data_sram_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;
  dsram_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DSRAM_WE_WD-1:0] l_we, a_we;
  logic [63:0] l_addr, a_addr, off;
  logic [DSRAM_DATA_WD-1:0] l_wdata, a_wdata;
  logic acc, fault, unused_bits;
  wire accept = state == DSRAM_IDLE && data_sram_en && LATENCY > 1;
  always_ff @(posedge clk)
    if (!rst_n) state <= DSRAM_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == DSRAM_IDLE ? (accept ? DSRAM_BUSY : DSRAM_IDLE)
                                   : (cnt == '0 ? DSRAM_IDLE : DSRAM_BUSY);
  always_comb begin
    stall_req = rst_n && LATENCY > 1 && (state == DSRAM_IDLE ? data_sram_en : cnt != '0);
    acc = rst_n && (LATENCY == 1 ? data_sram_en : state == DSRAM_BUSY && cnt == '0);
  end
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (accept) cnt <= CW'(LATENCY - 2);
    else if (state == DSRAM_BUSY && cnt != '0) cnt <= cnt - 1'b1;
  // The held request is re-presented while busy, so only the IDLE copy is captured
  always_ff @(posedge clk)
    if (accept) begin
      l_we <= data_sram_we;
      l_addr <= data_sram_addr;
      l_wdata <= data_sram_wdata;
    end
  assign a_we = LATENCY == 1 ? data_sram_we : l_we;
  assign a_addr = LATENCY == 1 ? data_sram_addr : l_addr;
  assign a_wdata = LATENCY == 1 ? data_sram_wdata : l_wdata;
  assign off = a_addr - BASE_ADDR;
`ifdef DSRAM_ERR_EN
  logic err_q;
  // DEPTH is a power of two, so in range means no offset bits above the index
  assign fault = off[63:AW+3] != '0;
  always_ff @(posedge clk)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= acc && fault;
  assign data_sram_err = err_q;
  assign unused_bits = ^off[2:0];
`else
  assign fault = 1'b0;
  assign data_sram_err = 1'b0;
  assign unused_bits = ^{off[63:AW+3], off[2:0]};
`endif
  dsram_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (acc),
    .fault (fault),
    .we    (a_we),
    .idx   (off[AW+2:3]),
    .wdata (a_wdata),
    .rdata (data_sram_rdata)
  );
endmodule
